cba_column_token_reader: RTL

// Column-end reader for the CBA pixel-region token chain. On an accepted trigger request it broadcasts the L1 ID to all regions.
// It then walks the token chain, strobing ReadData once per triggered hit, and captures the shared region data bus.

---
 rtl/cba_readout_pkg.sv | 31 +++
 rtl/cba_sync_fifo.sv | 55 +++++
 rtl/cba_column_token_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cba_readout_pkg.sv
// Shared types for the CBA column-end token reader: FSM states, the output
// word layout and the position of the timeout flag inside the EOE payload.
package cba_readout_pkg;

  localparam int CBA_DATA_BITS = 16;
  localparam int CBA_L1ID_BITS = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    READ   = 3'd3,
    EOE    = 3'd4
  } state_t;

  // Output word for the default widths; the top builds the same layout by
  // concatenation so it stays correct for any DATA_BITS/L1ID_BITS.
  typedef struct packed {
    logic                     eoe;
    logic [CBA_L1ID_BITS-1:0] l1id;
    logic [CBA_DATA_BITS-1:0] payload;
  } out_word_t;

  localparam int CBA_EOE_TIMEOUT_BIT = CBA_DATA_BITS - 1;

  // Timeout flag sits in the MSB of the payload; hit count uses the rest.
  function automatic int eoe_timeout_bit(input int data_bits);
    return data_bits - 1;
  endfunction

endpackage

// File: rtl/cba_sync_fifo.sv
// Synchronous FIFO for column readout words. Full/empty come from the
// registered occupancy count, so a pop in the same cycle never frees room
// for a push. Read data is the head entry and holds until popped.
module cba_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cba_column_token_reader.sv
// Column-end reader for the CBA token chain. Broadcasts the trigger L1 ID,
// walks the token chain with one ReadData strobe per hit, queues hit words
// and closes each event with an EOE word carrying the hit count.
// Optional hit limit per event: define CBA_READ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a trigger request (ReqReady high)
// SETTLE | letting token chain / data bus settle after L1Req or strobe
// CHECK  | sampling TokChain: read another hit or finish the event
// READ   | single-cycle strobe; DataBus captured into the FIFO
// EOE    | pushing the end-of-event word once the FIFO has room
module cba_column_token_reader
  import cba_readout_pkg::*;
#(
  parameter int DATA_BITS     = CBA_DATA_BITS,
  parameter int L1ID_BITS     = CBA_L1ID_BITS,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_READS     = 64
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic [L1ID_BITS-1:0]           ReqL1Id,
  output logic [L1ID_BITS-1:0]           L1Req,
  input  logic                           TokChain,
  output logic                           ReadData,
  input  logic [DATA_BITS-1:0]           DataBus,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [DATA_BITS+L1ID_BITS:0]   OutData,
  output logic                           Busy
);

  localparam int WORD_BITS   = DATA_BITS + L1ID_BITS + 1;
  localparam int CNT_BITS    = DATA_BITS - 1;
  localparam int SETTLE_BITS = $clog2(SETTLE_CYCLES) + 1;
  localparam int TO_BIT      = eoe_timeout_bit(DATA_BITS);
  localparam logic [SETTLE_BITS-1:0] SETTLE_RELOAD = SETTLE_BITS'(SETTLE_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [SETTLE_BITS-1:0] settle_cnt;
  logic [CNT_BITS-1:0]    hit_cnt;
  logic [L1ID_BITS-1:0]   l1req_q;
  logic                   timeout_flag;
  logic                   accept;
  logic                   read_strobe;
  logic                   push;
  logic [WORD_BITS-1:0]   push_data;
  logic [DATA_BITS-1:0]   eoe_payload;
  logic                   fifo_full;
  logic                   fifo_empty;

`ifdef CBA_READ_TIMEOUT_EN
  logic timeout_hit;
`else
  logic unused_max_reads;
  assign unused_max_reads = (MAX_READS > 0);
  assign timeout_flag     = 1'b0;
`endif

  assign ReqReady = (state == IDLE);
  assign Busy     = (state != IDLE);
  assign ReadData = read_strobe;
  assign L1Req    = l1req_q;
  assign OutValid = ~fifo_empty;

  // EOE payload: saturating hit count in the low bits, timeout flag on top.
  always_comb begin
    eoe_payload                 = '0;
    eoe_payload[CNT_BITS-1:0]   = hit_cnt;
    eoe_payload[TO_BIT]         = timeout_flag;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode, read strobe and FIFO push request.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    read_strobe = 1'b0;
    push        = 1'b0;
    push_data   = '0;
`ifdef CBA_READ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ReqValid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = CHECK;
      end
      CHECK: begin
        if (!TokChain) begin
          state_nxt = EOE;
`ifdef CBA_READ_TIMEOUT_EN
        end else if (hit_cnt == CNT_BITS'(MAX_READS)) begin
          // Limit reached with hits still pending: abandon the rest.
          timeout_hit = 1'b1;
          state_nxt   = EOE;
`endif
        end else if (!fifo_full) begin
          state_nxt = READ;
        end
      end
      READ: begin
        read_strobe = 1'b1;
        push        = 1'b1;
        push_data   = {1'b0, l1req_q, DataBus};
        state_nxt   = SETTLE;
      end
      EOE: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = {1'b1, l1req_q, eoe_payload};
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // L1 ID register, settle down-counter and saturating hit counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      l1req_q    <= '0;
      settle_cnt <= '0;
      hit_cnt    <= '0;
    end else begin
      if (accept) begin
        l1req_q    <= ReqL1Id;
        settle_cnt <= SETTLE_RELOAD;
        hit_cnt    <= '0;
      end
      if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      if (read_strobe) begin
        settle_cnt <= SETTLE_RELOAD;
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

`ifdef CBA_READ_TIMEOUT_EN
  // Timeout flag for the current event, cleared on each new request.
  always_ff @(posedge Clk) begin
    if (Reset)            timeout_flag <= 1'b0;
    else if (accept)      timeout_flag <= 1'b0;
    else if (timeout_hit) timeout_flag <= 1'b1;
  end
`endif

  cba_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .wdata (push_data),
    .pop   (OutReady),
    .rdata (OutData),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
